sba_mem_resp: RTL and testbench



---
 rtl/sba_mem_resp.sv | 133 +++++++++++++
 tb/tb_sba_mem_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sba_mem_resp.sv
// Memory-mapped SBA bus responder: word-addressed scratch array behind a req/gnt/r_valid
// interface with byte enables, a fixed response latency, range errors and saturating counters.
module sba_mem_resp #(
  parameter int unsigned BusWidth    = 32,
  parameter int unsigned Depth       = 256,
  parameter logic [63:0] BaseAddr    = 64'h0,
  parameter int unsigned RespLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  slave_req_i,
  input  logic [BusWidth-1:0]   slave_add_i,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  output logic                  slave_gnt_o,
  output logic                  slave_r_valid_o,
  output logic [BusWidth-1:0]   slave_r_rdata_o,
  output logic                  slave_r_err_o,
  output logic [15:0]           num_reads_o,
  output logic [15:0]           num_writes_o
);

  localparam int unsigned NumBytes = BusWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(Depth);
  localparam logic [BusWidth:0] WinBytes = (BusWidth + 1)'(Depth * NumBytes);
  localparam logic [3:0] LatInit = 4'(RespLatency - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01
  } state_e;

  state_e              r_state;
  logic [3:0]          r_lat_cnt;
  logic                r_pend_we;
  logic                r_pend_err;
  logic [BusWidth-1:0] r_pend_rdata;
  logic                r_valid;
  logic                r_err;
  logic [BusWidth-1:0] r_rdata;
  logic [15:0]         r_num_reads;
  logic [15:0]         r_num_writes;
  logic [BusWidth-1:0] r_mem [Depth];

  logic [BusWidth-1:0] w_off;
  logic                w_in_range;
  logic [IdxW-1:0]     w_idx;
  logic                w_gnt;
  logic [BusWidth-1:0] w_resp_rdata;

  // Modular subtraction lets the window sit anywhere, including the top of the address map.
  assign w_off        = slave_add_i - BaseAddr[BusWidth-1:0];
  assign w_in_range   = {1'b0, w_off} < WinBytes;
  assign w_idx        = w_off[OffW +: IdxW];
  assign w_gnt        = (r_state == StIdle) && slave_req_i && !stall_i;
  assign w_resp_rdata = (slave_we_i || !w_in_range) ? '0 : r_mem[w_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_lat_cnt    <= '0;
      r_pend_we    <= 1'b0;
      r_pend_err   <= 1'b0;
      r_pend_rdata <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_num_reads  <= '0;
      r_num_writes <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
              if (slave_we_i && w_in_range && slave_be_i[b]) begin
                r_mem[w_idx][8*b +: 8] <= slave_wdata_i[8*b +: 8];
              end
            end
            r_pend_we    <= slave_we_i;
            r_pend_err   <= !w_in_range;
            r_pend_rdata <= w_resp_rdata;
            r_lat_cnt    <= LatInit;
            r_state      <= StWait;
            // Registered response: raise it one edge early so it lands at grant + latency.
            if (RespLatency == 1) begin
              r_valid <= 1'b1;
              r_err   <= !w_in_range;
              r_rdata <= w_resp_rdata;
            end
          end
        end
        StWait: begin
          if (r_lat_cnt == 4'd0) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (r_pend_we) begin
              if (r_num_writes != 16'hFFFF) r_num_writes <= r_num_writes + 16'd1;
            end else begin
              if (r_num_reads != 16'hFFFF) r_num_reads <= r_num_reads + 16'd1;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
            if (r_lat_cnt == 4'd1) begin
              r_valid <= 1'b1;
              r_err   <= r_pend_err;
              r_rdata <= r_pend_rdata;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_valid <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign slave_gnt_o     = w_gnt;
  assign slave_r_valid_o = r_valid;
  assign slave_r_rdata_o = r_rdata;
  assign slave_r_err_o   = r_err;
  assign num_reads_o     = r_num_reads;
  assign num_writes_o    = r_num_writes;

endmodule

// File: tb/tb_sba_mem_resp.sv
// Directed bench for sba_mem_resp: one responder at latency 1 and one at latency 4, with a
// byte-level memory model feeding an expected-response queue.
module tb_sba_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        req1, req4;
  logic        we;
  logic [31:0] add, wdata;
  logic [3:0]  be;

  logic        gnt1, rv1, err1, gnt4, rv4, err4;
  logic [31:0] rdata1, rdata4;
  logic [15:0] nr1, nw1, nr4, nw4;

  always #5 clk = ~clk;

  sba_mem_resp #(.BusWidth(32), .Depth(256), .BaseAddr(64'h0), .RespLatency(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .slave_req_i(req1), .slave_add_i(add),
    .slave_we_i(we), .slave_wdata_i(wdata), .slave_be_i(be), .slave_gnt_o(gnt1),
    .slave_r_valid_o(rv1), .slave_r_rdata_o(rdata1), .slave_r_err_o(err1),
    .num_reads_o(nr1), .num_writes_o(nw1)
  );

  sba_mem_resp #(.BusWidth(32), .Depth(256), .BaseAddr(64'h0), .RespLatency(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .slave_req_i(req4), .slave_add_i(add),
    .slave_we_i(we), .slave_wdata_i(wdata), .slave_be_i(be), .slave_gnt_o(gnt4),
    .slave_r_valid_o(rv4), .slave_r_rdata_o(rdata4), .slave_r_err_o(err4),
    .num_reads_o(nr4), .num_writes_o(nw4)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q_exp[$];
  logic [31:0] mem_m [2][256];
  logic [15:0] nr_m [2];
  logic [15:0] nw_m [2];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic gnt_of(input int sel);
    return sel != 0 ? gnt4 : gnt1;
  endfunction

  function automatic logic rv_of(input int sel);
    return sel != 0 ? rv4 : rv1;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) mem_m[s][i] = '0;
      nr_m[s] = '0;
      nw_m[s] = '0;
    end
  endtask

  // One full transaction: optional stall cycles, same-cycle grant, exact response timing.
  task automatic xact(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int stall_cyc);
    exp_t e;
    int   lat;
    logic inr;
    int   idx;
    lat = (sel != 0) ? 4 : 1;
    inr = a < 32'h400;
    idx = int'(a[9:2]);
    e.err = !inr;
    if (w) begin
      e.rdata = '0;
      if (inr) begin
        for (int i = 0; i < 4; i++) if (b[i]) mem_m[sel][idx][8*i +: 8] = d[8*i +: 8];
      end
      nw_m[sel] = sat_inc(nw_m[sel]);
    end else begin
      e.rdata = inr ? mem_m[sel][idx] : 32'h0;
      nr_m[sel] = sat_inc(nr_m[sel]);
    end
    q_exp.push_back(e);

    @(negedge clk);
    we = w; add = a; wdata = d; be = b;
    stall = (stall_cyc > 0);
    if (sel != 0) req4 = 1'b1; else req1 = 1'b1;
    for (int k = 0; k < stall_cyc; k++) begin
      #1 chk("stall_gnt", 32'(gnt_of(sel)), 32'h0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1 chk("gnt_same_cycle", 32'(gnt_of(sel)), 32'h1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1;
      chk("wait_gnt", 32'(gnt_of(sel)), 32'h0);
      chk("r_valid_timing", 32'(rv_of(sel)), 32'(k == lat));
      if (k == lat) begin
        e = q_exp.pop_front();
        chk("r_rdata", (sel != 0) ? rdata4 : rdata1, e.rdata);
        chk("r_err", 32'((sel != 0) ? err4 : err1), 32'(e.err));
        if (sel != 0) req4 = 1'b0; else req1 = 1'b0;
      end
    end
  endtask

  task automatic chk_counts(input int sel);
    @(negedge clk);
    #1;
    chk("num_reads", 32'((sel != 0) ? nr4 : nr1), 32'(nr_m[sel]));
    chk("num_writes", 32'((sel != 0) ? nw4 : nw1), 32'(nw_m[sel]));
  endtask

  initial begin
    logic seen_rv;
    rst_n = 1'b0; stall = 1'b0; req1 = 1'b0; req4 = 1'b0;
    we = 1'b0; add = '0; wdata = '0; be = '0;
    clear_model();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rv", 32'(rv1), 32'h0);
    chk("rst_err", 32'(err4), 32'h0);
    chk("rst_rdata", rdata1, 32'h0);
    chk("rst_nr", 32'(nr4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
    chk_counts(0);

    // Byte enables, read data held after the response
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("be_merge_hold", rdata1, 32'h11BB33DD);

    // Out of range must neither read nor alias onto word 0
    xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0);
    xact(0, 1'b0, 32'h400, 32'h0, 4'hF, 0);
    xact(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, 0);
    chk("oor_no_alias", rdata1, 32'hCAFEF00D);
    chk_counts(0);

    // Latency 4 with backpressure, then read-after-write
    xact(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 3);
    xact(1, 1'b0, 32'h40, 32'h0, 4'hF, 0);
    xact(1, 1'b0, 32'h3FC, 32'h0, 4'hF, 2);
    chk_counts(1);

    // Reset two cycles after a read grant drops the response
    @(negedge clk);
    we = 1'b0; add = 32'h40; be = 4'hF; req4 = 1'b1;
    #1 chk("rst_test_gnt", 32'(gnt4), 32'h1);
    @(negedge clk);
    req4 = 1'b0;
    seen_rv = rv4;
    @(negedge clk);
    seen_rv |= rv4;
    rst_n = 1'b0;
    clear_model();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1 seen_rv |= rv4;
      if (k == 1) rst_n = 1'b1;
    end
    chk("no_rv_after_reset", 32'(seen_rv), 32'h0);
    chk_counts(0);
    chk_counts(1);
    xact(1, 1'b0, 32'h40, 32'h0, 4'hF, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);

    // Saturation of the read counter
    @(negedge clk);
    force u_dut1.r_num_reads = 16'hFFFE;
    @(negedge clk);
    release u_dut1.r_num_reads;
    nr_m[0] = 16'hFFFE;
    #1 chk("forced_nr", 32'(nr1), 32'h0000FFFE);
    for (int r = 0; r < 3; r++) begin
      xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
      chk_counts(0);
    end
    chk("nr_saturated", 32'(nr1), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
